// File: rtl/stg_wb_q.sv
// Writeback stage: in-order retirement queue draining into the GP/SR/AR register-file write ports.
// Optional retired-entry counter enabled by defining WB_RETIRE_CNT_EN.
module stg_wb_q #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 48,
  parameter int unsigned GP_AW  = 4,
  parameter int unsigned SR_AW  = 2,
  parameter int unsigned AR_AW  = 2
) (
  input  logic                       iw_clk,
  input  logic                       iw_rst,
  input  logic                       iw_valid,
  output logic                       ow_ready,
  input  logic [ADDR_W-1:0]          iw_pc,
  input  logic [DATA_W-1:0]          iw_instr,
  input  logic [GP_AW-1:0]           iw_tgt_gp,
  input  logic                       iw_tgt_gp_we,
  input  logic [DATA_W-1:0]          iw_result,
  input  logic [SR_AW-1:0]           iw_tgt_sr,
  input  logic                       iw_tgt_sr_we,
  input  logic [ADDR_W-1:0]          iw_sr_result,
  input  logic [AR_AW-1:0]           iw_tgt_ar,
  input  logic                       iw_tgt_ar_we,
  input  logic [ADDR_W-1:0]          iw_ar_result,
  input  logic                       iw_rf_ready,
  output logic [GP_AW-1:0]           ow_gp_write_addr,
  output logic [DATA_W-1:0]          ow_gp_write_data,
  output logic                       ow_gp_write_enable,
  output logic [SR_AW-1:0]           ow_sr_write_addr,
  output logic [ADDR_W-1:0]          ow_sr_write_data,
  output logic                       ow_sr_write_enable,
  output logic [AR_AW-1:0]           ow_ar_write_addr,
  output logic [ADDR_W-1:0]          ow_ar_write_data,
  output logic                       ow_ar_write_enable,
  input  logic [GP_AW-1:0]           iw_fwd_gp_addr,
  output logic                       ow_fwd_gp_hit,
  output logic [DATA_W-1:0]          ow_fwd_gp_data,
  output logic [$clog2(DEPTH):0]     ow_count,
  output logic                       ow_empty,
  output logic [ADDR_W-1:0]          ow_pc,
`ifdef WB_RETIRE_CNT_EN
  input  logic                       iw_retire_cnt_clr,
  output logic [ADDR_W-1:0]          ow_retire_cnt,
`endif
  output logic [DATA_W-1:0]          ow_instr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [GP_AW-1:0]  tgt_gp;
    logic              gp_we;
    logic [DATA_W-1:0] result;
    logic [SR_AW-1:0]  tgt_sr;
    logic              sr_we;
    logic [ADDR_W-1:0] sr_result;
    logic [AR_AW-1:0]  tgt_ar;
    logic              ar_we;
    logic [ADDR_W-1:0] ar_result;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            entry_in;
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic              push, pop;
  logic [PTR_W-1:0]  scan_idx;

  assign entry_in = '{pc: iw_pc, instr: iw_instr, tgt_gp: iw_tgt_gp, gp_we: iw_tgt_gp_we,
                      result: iw_result, tgt_sr: iw_tgt_sr, sr_we: iw_tgt_sr_we,
                      sr_result: iw_sr_result, tgt_ar: iw_tgt_ar, ar_we: iw_tgt_ar_we,
                      ar_result: iw_ar_result};

  assign head     = mem_q[rd_ptr_q];
  // A grant frees the head slot this cycle, so a full queue may still accept.
  assign ow_ready = (count_q < CNT_W'(DEPTH)) || iw_rf_ready;
  assign push     = iw_valid && ow_ready;
  assign pop      = (count_q != '0) && iw_rf_ready;
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= '0;
      instr_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        pc_q     <= head.pc;
        instr_q  <= head.instr;
      end
    end
  end

  // Payload storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge iw_clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_in;
  end

  always_comb begin
    ow_gp_write_enable = pop && head.gp_we;
    ow_gp_write_addr   = head.tgt_gp;
    ow_gp_write_data   = head.result;
    ow_sr_write_enable = pop && head.sr_we;
    ow_sr_write_addr   = head.tgt_sr;
    ow_sr_write_data   = head.sr_result;
    ow_ar_write_enable = pop && head.ar_we;
    ow_ar_write_addr   = head.tgt_ar;
    ow_ar_write_data   = head.ar_result;
  end

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    ow_fwd_gp_hit  = 1'b0;
    ow_fwd_gp_data = '0;
    scan_idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && mem_q[scan_idx].gp_we &&
          (mem_q[scan_idx].tgt_gp == iw_fwd_gp_addr)) begin
        ow_fwd_gp_hit  = 1'b1;
        ow_fwd_gp_data = mem_q[scan_idx].result;
      end
    end
  end

  assign ow_count = count_q;
  assign ow_empty = (count_q == '0);
  assign ow_pc    = pc_q;
  assign ow_instr = instr_q;

`ifdef WB_RETIRE_CNT_EN
  logic [ADDR_W-1:0] retire_cnt_q;

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      retire_cnt_q <= '0;
    end else if (iw_retire_cnt_clr) begin
      retire_cnt_q <= '0;
    end else if (pop) begin
      retire_cnt_q <= retire_cnt_q + ADDR_W'(1);
    end
  end

  assign ow_retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_stg_wb_q.sv
// Directed self-checking bench for stg_wb_q (DEPTH=4) with a small queue scoreboard.
// Exercises the retire counter too when WB_RETIRE_CNT_EN is defined.
module tb_stg_wb_q;

  typedef struct packed {
    logic [47:0] pc;
    logic [23:0] instr;
    logic [3:0]  tgt_gp;
    logic        gp_we;
    logic [23:0] result;
    logic [1:0]  tgt_sr;
    logic        sr_we;
    logic [47:0] sr_result;
    logic [1:0]  tgt_ar;
    logic        ar_we;
    logic [47:0] ar_result;
  } ent_t;

  logic        iw_clk, iw_rst, iw_valid, ow_ready;
  logic [47:0] iw_pc;
  logic [23:0] iw_instr;
  logic [3:0]  iw_tgt_gp;
  logic        iw_tgt_gp_we;
  logic [23:0] iw_result;
  logic [1:0]  iw_tgt_sr;
  logic        iw_tgt_sr_we;
  logic [47:0] iw_sr_result;
  logic [1:0]  iw_tgt_ar;
  logic        iw_tgt_ar_we;
  logic [47:0] iw_ar_result;
  logic        iw_rf_ready;
  logic [3:0]  ow_gp_write_addr;
  logic [23:0] ow_gp_write_data;
  logic        ow_gp_write_enable;
  logic [1:0]  ow_sr_write_addr;
  logic [47:0] ow_sr_write_data;
  logic        ow_sr_write_enable;
  logic [1:0]  ow_ar_write_addr;
  logic [47:0] ow_ar_write_data;
  logic        ow_ar_write_enable;
  logic [3:0]  iw_fwd_gp_addr;
  logic        ow_fwd_gp_hit;
  logic [23:0] ow_fwd_gp_data;
  logic [2:0]  ow_count;
  logic        ow_empty;
  logic [47:0] ow_pc;
  logic [23:0] ow_instr;
`ifdef WB_RETIRE_CNT_EN
  logic        iw_retire_cnt_clr;
  logic [47:0] ow_retire_cnt;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t mq[$];
  ent_t idle_e;
  logic [47:0] last_pc;
  logic [23:0] last_instr;

  stg_wb_q dut (
    .iw_clk             (iw_clk),
    .iw_rst             (iw_rst),
    .iw_valid           (iw_valid),
    .ow_ready           (ow_ready),
    .iw_pc              (iw_pc),
    .iw_instr           (iw_instr),
    .iw_tgt_gp          (iw_tgt_gp),
    .iw_tgt_gp_we       (iw_tgt_gp_we),
    .iw_result          (iw_result),
    .iw_tgt_sr          (iw_tgt_sr),
    .iw_tgt_sr_we       (iw_tgt_sr_we),
    .iw_sr_result       (iw_sr_result),
    .iw_tgt_ar          (iw_tgt_ar),
    .iw_tgt_ar_we       (iw_tgt_ar_we),
    .iw_ar_result       (iw_ar_result),
    .iw_rf_ready        (iw_rf_ready),
    .ow_gp_write_addr   (ow_gp_write_addr),
    .ow_gp_write_data   (ow_gp_write_data),
    .ow_gp_write_enable (ow_gp_write_enable),
    .ow_sr_write_addr   (ow_sr_write_addr),
    .ow_sr_write_data   (ow_sr_write_data),
    .ow_sr_write_enable (ow_sr_write_enable),
    .ow_ar_write_addr   (ow_ar_write_addr),
    .ow_ar_write_data   (ow_ar_write_data),
    .ow_ar_write_enable (ow_ar_write_enable),
    .iw_fwd_gp_addr     (iw_fwd_gp_addr),
    .ow_fwd_gp_hit      (ow_fwd_gp_hit),
    .ow_fwd_gp_data     (ow_fwd_gp_data),
    .ow_count           (ow_count),
    .ow_empty           (ow_empty),
    .ow_pc              (ow_pc),
`ifdef WB_RETIRE_CNT_EN
    .iw_retire_cnt_clr  (iw_retire_cnt_clr),
    .ow_retire_cnt      (ow_retire_cnt),
`endif
    .ow_instr           (ow_instr)
  );

  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic [47:0] pc, input logic gw, input logic [3:0] t,
                              input logic [23:0] r);
    ent_t e;
    e        = '0;
    e.pc     = pc;
    e.instr  = {pc[11:0], 12'hC3C};
    e.gp_we  = gw;
    e.tgt_gp = t;
    e.result = r;
    return e;
  endfunction

  task automatic drive(input ent_t e, input logic valid, input logic rf);
    iw_valid     = valid;
    iw_rf_ready  = rf;
    iw_pc        = e.pc;
    iw_instr     = e.instr;
    iw_tgt_gp    = e.tgt_gp;
    iw_tgt_gp_we = e.gp_we;
    iw_result    = e.result;
    iw_tgt_sr    = e.tgt_sr;
    iw_tgt_sr_we = e.sr_we;
    iw_sr_result = e.sr_result;
    iw_tgt_ar    = e.tgt_ar;
    iw_tgt_ar_we = e.ar_we;
    iw_ar_result = e.ar_result;
  endtask

  // One clock: drive at negedge, check comb outputs, then check state after the edge.
  task automatic do_cycle(input ent_t e, input logic valid, input logic rf);
    logic  exp_ready, exp_pop, exp_hit;
    logic [23:0] exp_fd;
    ent_t  h;
    @(negedge iw_clk);
    drive(e, valid, rf);
    #1;
    exp_ready = (mq.size() < 4) || rf;
    exp_pop   = (mq.size() > 0) && rf;
    h         = exp_pop ? mq[0] : '0;
    exp_hit   = 1'b0;
    exp_fd    = '0;
    foreach (mq[i]) begin
      if (mq[i].gp_we && mq[i].tgt_gp == iw_fwd_gp_addr) begin
        exp_hit = 1'b1;
        exp_fd  = mq[i].result;
      end
    end
    check("ready", 64'(ow_ready), 64'(exp_ready));
    check("gp_we", 64'(ow_gp_write_enable), 64'(exp_pop && h.gp_we));
    check("sr_we", 64'(ow_sr_write_enable), 64'(exp_pop && h.sr_we));
    check("ar_we", 64'(ow_ar_write_enable), 64'(exp_pop && h.ar_we));
    if (exp_pop && h.gp_we) begin
      check("gp_addr", 64'(ow_gp_write_addr), 64'(h.tgt_gp));
      check("gp_data", 64'(ow_gp_write_data), 64'(h.result));
    end
    if (exp_pop && h.sr_we) begin
      check("sr_addr", 64'(ow_sr_write_addr), 64'(h.tgt_sr));
      check("sr_data", 64'(ow_sr_write_data), 64'(h.sr_result));
    end
    if (exp_pop && h.ar_we) begin
      check("ar_addr", 64'(ow_ar_write_addr), 64'(h.tgt_ar));
      check("ar_data", 64'(ow_ar_write_data), 64'(h.ar_result));
    end
    check("fwd_hit", 64'(ow_fwd_gp_hit), 64'(exp_hit));
    check("fwd_data", 64'(ow_fwd_gp_data), 64'(exp_fd));
    @(posedge iw_clk);
    if (exp_pop) begin
      last_pc    = h.pc;
      last_instr = h.instr;
      void'(mq.pop_front());
    end
    if (valid && exp_ready) mq.push_back(e);
    #1;
    check("count", 64'(ow_count), 64'(mq.size()));
    check("empty", 64'(ow_empty), 64'(mq.size() == 0));
    check("pc", 64'(ow_pc), 64'(last_pc));
    check("instr", 64'(ow_instr), 64'(last_instr));
  endtask

  initial begin
    ent_t e;
    idle_e         = '0;
    last_pc        = '0;
    last_instr     = '0;
    iw_fwd_gp_addr = 4'd3;
`ifdef WB_RETIRE_CNT_EN
    iw_retire_cnt_clr = 1'b0;
`endif
    drive(idle_e, 1'b0, 1'b1);
    iw_rst = 1'b1;
    repeat (2) @(posedge iw_clk);
    #1;
    check("rst_count", 64'(ow_count), 64'd0);
    check("rst_empty", 64'(ow_empty), 64'd1);
    check("rst_pc", 64'(ow_pc), 64'd0);
    check("rst_instr", 64'(ow_instr), 64'd0);
    check("rst_gp_we", 64'(ow_gp_write_enable), 64'd0);
    check("rst_hit", 64'(ow_fwd_gp_hit), 64'd0);
    @(negedge iw_clk);
    iw_rst = 1'b0;

    // Single entry through an empty queue: 1-cycle latency, no bypass.
    do_cycle(mk(48'h10, 1'b1, 4'd3, 24'h00ABCD), 1'b1, 1'b1);
    do_cycle(idle_e, 1'b0, 1'b1);
    check("t1_pc", 64'(ow_pc), 64'h10);

    // Fill with the port stalled; the fifth entry must be refused.
    for (int k = 0; k < 5; k++)
      do_cycle(mk(48'h100 + 48'(k), 1'b1, 4'(k), 24'h200 + 24'(k)), 1'b1, 1'b0);
    check("full_count", 64'(ow_count), 64'd4);

    // Full queue with simultaneous push and pop; the held fifth entry goes in first.
    for (int k = 4; k < 12; k++)
      do_cycle(mk(48'h100 + 48'(k), 1'b1, 4'(k), 24'h200 + 24'(k)), 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) do_cycle(idle_e, 1'b0, 1'b1);
    check("drain_pc", 64'(ow_pc), 64'h10B);

    // SR+AR entry, then an entry with no write enables that still retires.
    e = mk(48'h300, 1'b0, 4'd0, 24'h0);
    e.sr_we = 1'b1; e.tgt_sr = 2'd2; e.sr_result = 48'hA5A5_0000_1234;
    e.ar_we = 1'b1; e.tgt_ar = 2'd1; e.ar_result = 48'h0000_FEED_BEEF;
    do_cycle(e, 1'b1, 1'b0);
    do_cycle(mk(48'h301, 1'b0, 4'd9, 24'h999), 1'b1, 1'b0);
    do_cycle(idle_e, 1'b0, 1'b1);
    do_cycle(idle_e, 1'b0, 1'b1);
    check("nowe_pc", 64'(ow_pc), 64'h301);

    // Forwarding: youngest match wins; same-cycle push is invisible.
    iw_fwd_gp_addr = 4'd5;
    do_cycle(mk(48'h400, 1'b1, 4'd5, 24'h111), 1'b1, 1'b0);
    do_cycle(mk(48'h401, 1'b1, 4'd7, 24'h333), 1'b1, 1'b0);
    do_cycle(mk(48'h402, 1'b1, 4'd5, 24'h222), 1'b1, 1'b0);
    do_cycle(idle_e, 1'b0, 1'b0);
    check("fwd5_data", 64'(ow_fwd_gp_data), 64'h222);
    iw_fwd_gp_addr = 4'd6;
    do_cycle(idle_e, 1'b0, 1'b0);
    check("fwd6_hit", 64'(ow_fwd_gp_hit), 64'd0);
    do_cycle(mk(48'h403, 1'b1, 4'd6, 24'h444), 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) do_cycle(idle_e, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a cycle with three entries queued.
    iw_fwd_gp_addr = 4'd1;
    for (int k = 0; k < 3; k++)
      do_cycle(mk(48'h500 + 48'(k), 1'b1, 4'(k), 24'h600 + 24'(k)), 1'b1, 1'b0);
    iw_valid = 1'b0;
    #2;
    iw_rst = 1'b1;
    #1;
    check("arst_count", 64'(ow_count), 64'd0);
    check("arst_empty", 64'(ow_empty), 64'd1);
    check("arst_pc", 64'(ow_pc), 64'd0);
    check("arst_instr", 64'(ow_instr), 64'd0);
    check("arst_hit", 64'(ow_fwd_gp_hit), 64'd0);
    iw_rf_ready = 1'b1;
    #1;
    check("arst_gp_we", 64'(ow_gp_write_enable), 64'd0);
    repeat (2) @(posedge iw_clk);
    @(negedge iw_clk);
    iw_rst = 1'b0;
    mq.delete();
    last_pc    = '0;
    last_instr = '0;
    for (int k = 0; k < 3; k++) do_cycle(idle_e, 1'b0, 1'b1);

`ifdef WB_RETIRE_CNT_EN
    check("rcnt_rst", 64'(ow_retire_cnt), 64'd0);
    for (int k = 0; k < 7; k++)
      do_cycle(mk(48'h700 + 48'(k), 1'b1, 4'(k), 24'h700 + 24'(k)), 1'b1, 1'b1);
    do_cycle(idle_e, 1'b0, 1'b1);
    check("rcnt_7", 64'(ow_retire_cnt), 64'd7);
    do_cycle(mk(48'h710, 1'b0, 4'd0, 24'h0), 1'b1, 1'b0);
    iw_retire_cnt_clr = 1'b1;
    do_cycle(idle_e, 1'b0, 1'b1);
    iw_retire_cnt_clr = 1'b0;
    check("rcnt_clr", 64'(ow_retire_cnt), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stg_wb_q.md
Name: stg_wb_q

Overview:
- Parametrised successor to the pass-through writeback stage.
- Accepts completed instructions from MEM by valid/ready. Buffers them in an in-order DEPTH-entry retirement queue and drains the head entry into the GP/SR/AR register files when the shared register-file write port grants (iw_rf_ready).
- Exposes a youngest-match GP forwarding lookup over queued entries.
- Registers the PC and instruction of the last retired entry for trace and debug.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- DATA_W, 24, GP data width.
- ADDR_W, 48, PC/SR/AR data width.
- GP_AW, 4, GP target index width.
- SR_AW, 2, SR target index width.
- AR_AW, 2, AR target index width.

Ports:
- iw_clk  in  1  clock, rising edge.
- iw_rst  in  1  reset, asynchronous, active-high.
- iw_valid  in  1  incoming entry valid.
- ow_ready  out  1  stage can accept this cycle.
- iw_pc  in  ADDR_W  PC of the entry.
- iw_instr  in  DATA_W  instruction word.
- iw_tgt_gp  in  GP_AW  GP target index.
- iw_tgt_gp_we  in  1  GP write enable.
- iw_result  in  DATA_W  GP write data.
- iw_tgt_sr  in  SR_AW  SR target index.
- iw_tgt_sr_we  in  1  SR write enable.
- iw_sr_result  in  ADDR_W  SR write data.
- iw_tgt_ar  in  AR_AW  AR target index.
- iw_tgt_ar_we  in  1  AR write enable.
- iw_ar_result  in  ADDR_W  AR write data.
- iw_rf_ready  in  1  register-file write port granted this cycle.
- ow_gp_write_addr / ow_gp_write_data / ow_gp_write_enable  out  GP_AW / DATA_W / 1  GP write port.
- ow_sr_write_addr / ow_sr_write_data / ow_sr_write_enable  out  SR_AW / ADDR_W / 1  SR write port.
- ow_ar_write_addr / ow_ar_write_data / ow_ar_write_enable  out  AR_AW / ADDR_W / 1  AR write port.
- iw_fwd_gp_addr  in  GP_AW  forwarding query index.
- ow_fwd_gp_hit  out  1  a queued entry targets the queried register.
- ow_fwd_gp_data  out  DATA_W  data from the youngest matching entry.
- ow_count  out  clog2(DEPTH)+1  queue occupancy.
- ow_empty  out  1  occupancy is 0.
- ow_pc  out  ADDR_W  PC of the last retired entry (registered).
- ow_instr  out  DATA_W  instruction of the last retired entry (registered).

Behaviour:
- Reset (async, iw_rst=1):
  - Queue empty; read/write pointers and count = 0.
  - ow_pc = 0, ow_instr = 0; all write enables = 0.
  - ow_fwd_gp_hit = 0, ow_empty = 1.
  - Reset mid-drain discards every queued entry; no write enable is asserted while reset is held.
- Push: accepted when iw_valid && ow_ready.
  - The entry stores all input fields at the write pointer on the rising edge.
- Pop: occurs when count > 0 && iw_rf_ready.
  - Write enables are combinational from the head entry: ow_gp_write_enable = pop && head.gp_we; SR and AR likewise.
  - Addresses and data are driven from the head entry.
  - One entry retires per cycle, and all of its enabled files are written in the same cycle.
  - On pop, the head PC and instr are registered into ow_pc / ow_instr.
- ow_ready = (count < DEPTH) || iw_rf_ready.
  - This is a combinational path from iw_rf_ready, by design.
  - At full, a simultaneous push and pop is legal: count stays at DEPTH.
- Count update: count' = count + push − pop.
  - Pointers wrap modulo DEPTH.
- Latency:
  - An entry pushed at edge N is first eligible to retire in cycle N+1.
  - The queue never bypasses an entry straight from input to output.
  - Minimum latency through an empty queue is 1 cycle.
- Empty queue: no write enables regardless of iw_rf_ready; ow_pc and ow_instr hold.
- An entry with all three write enables = 0 still occupies a slot and retires normally, updating ow_pc / ow_instr.
- Forwarding lookup:
  - Scans valid entries only, from youngest (write pointer − 1) to oldest (head).
  - The first entry with gp_we && tgt_gp == iw_fwd_gp_addr sets hit = 1 and supplies its data.
  - The entry being pushed in the same cycle is not visible to the lookup.
  - The head entry being popped that cycle is visible.
  - No match gives hit = 0 and data = 0.
- Ordering: retirement is strictly in push order; no reordering and no drops.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Adds output ow_retire_cnt, width ADDR_W.
  - Reset value 0; increments by 1 on every pop; wraps from all-ones to 0.
  - Adds input iw_retire_cnt_clr; synchronous clear to 0, with priority over increment in the same cycle.
- When undefined: neither port exists and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset, then push pc=0x10, gp_we=1, tgt=3, result=0x00ABCD with iw_rf_ready=1 -> next cycle ow_gp_write_enable=1, addr 3, data 0x00ABCD; following cycle ow_pc=0x10; ow_empty returns to 1.
- iw_rf_ready=0, push 5 entries back-to-back (DEPTH=4) -> ow_ready drops after the 4th accept; ow_count=4; 5th entry held; no write enables asserted.
- Full queue, iw_rf_ready=1, iw_valid=1 -> push and pop in the same cycle; ow_count stays 4; retire order matches push order over 8 entries.
- Queue holds gp tgt=5 with data 0x111 (older) and 0x222 (younger), query addr 5 -> hit=1, data 0x222; query addr 6 -> hit=0, data 0.
- Assert iw_rst asynchronously mid-cycle with 3 entries queued -> outputs clear immediately; ow_count=0, ow_pc=0; no write enable pulses after release.
- With WB_RETIRE_CNT_EN: retire 7 entries -> ow_retire_cnt=7; pulse clr together with a pop -> ow_retire_cnt=0.
